// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags/handshake in, datapath controls and status out.
interface multicycle_ctrl_if;
  logic [10:0] Op;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        IRWrite;
  logic        Reg2Loc;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        PCSrc;
  logic [1:0]  ALUOp;
  logic [3:0]  state;
  logic        instr_done;
  logic        fault;
  logic [15:0] instret;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, PCSrc,
    output ALUOp, state, instr_done, fault, instret
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, PCSrc,
    input  ALUOp, state, instr_done, fault, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for a small LEGv8 subset (LDUR, STUR, CBZ, ADD, SUB, AND, ORR).
// A memory wait that runs for TIMEOUT cycles, or an unknown opcode, parks the FSM in HALT.
//
// state  | meaning
// FETCH  | load instruction register
// DECODE | classify opcode
// ADDR   | compute load/store address
// MEMRD  | wait for load data
// LDWB   | write load data back, retire
// MEMWR  | wait for store completion, retire on ready
// RTYPE  | ALU operation
// RWB    | write ALU result back, retire
// CBZ    | branch decision, retire
// HALT   | illegal opcode or memory timeout; exit only by reset
module multicycle_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEMRD  = 4'd3,
    S_LDWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_RWB    = 4'd7,
    S_CBZ    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt;
  logic [15:0]      instret_q;
  logic             is_ldur, is_stur, is_cbz, is_rtype;
  logic             in_mem, wait_expired;
  logic             pc_write, ir_write, reg2loc, alu_src, mem_to_reg;
  logic             reg_write, mem_read, mem_write, pc_src;
  logic [1:0]       alu_op;

  // Opcode classification; Op stays stable from DECODE until the next FETCH.
  always_comb begin
    is_ldur  = (bus.Op == 11'b11111000010);
    is_stur  = (bus.Op == 11'b11111000000);
    is_cbz   = (bus.Op[10:3] == 8'b10110100);
    is_rtype = (bus.Op == 11'b10001011000) || (bus.Op == 11'b11001011000) ||
               (bus.Op == 11'b10001010000) || (bus.Op == 11'b10101010000);
  end

  assign in_mem       = (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Last permitted wait cycle: without ready now, the access has waited TIMEOUT cycles.
  assign wait_expired = (wait_cnt == WCW'(TIMEOUT - 1));

  // Next-state and control decode; ready takes priority over timeout.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        reg2loc = is_stur || is_cbz;
        if (is_ldur || is_stur) state_d = S_ADDR;
        else if (is_rtype)      state_d = S_RTYPE;
        else if (is_cbz)        state_d = S_CBZ;
        else                    state_d = S_HALT;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        reg2loc = is_stur;
        state_d = is_ldur ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        if (bus.mem_ready)      state_d = S_LDWB;
        else if (wait_expired)  state_d = S_HALT;
      end
      S_LDWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        reg2loc   = 1'b1;
        if (bus.mem_ready) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else if (wait_expired) begin
          state_d  = S_HALT;
        end
      end
      S_RTYPE: begin
        alu_op  = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_CBZ: begin
        alu_op   = 2'b01;
        pc_write = 1'b1;
        pc_src   = bus.Zero;
        reg2loc  = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Memory wait counter: counts not-ready cycles in MEMRD/MEMWR, zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         wait_cnt <= '0;
    else if (in_mem && !bus.mem_ready) wait_cnt <= wait_cnt + WCW'(1);
    else                               wait_cnt <= '0;
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instret_q <= 16'd0;
    else if (pc_write) instret_q <= instret_q + 16'd1;
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IRWrite    = ir_write;
  assign bus.Reg2Loc    = reg2loc;
  assign bus.ALUSrc     = alu_src;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.PCSrc      = pc_src;
  assign bus.ALUOp      = alu_op;
  assign bus.state      = state_q;
  assign bus.instr_done = pc_write;
  assign bus.fault      = (state_q == S_HALT);
  assign bus.instret    = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum memory wait cycles before a fault.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Op  input  11  instruction opcode field; sampled in DECODE and held stable by the datapath until the next FETCH.
REQ-005 SHALL have port Zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  data memory completion handshake.
REQ-007 SHALL have port PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, PCSrc  output  1 each  datapath controls.
REQ-008 SHALL have port ALUOp  output  2  ALU operation class.
REQ-009 SHALL have port state  output  4  current state encoding.
REQ-010 SHALL have port instr_done  output  1  one-cycle pulse on instruction retire.
REQ-011 SHALL have port fault  output  1  sticky illegal-opcode/timeout flag.
REQ-012 SHALL have port instret  output  16  retired instruction counter.

Function
REQ-013 SHALL decode: LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000; all others illegal.
REQ-014 SHALL implement states FETCH=0, DECODE=1, ADDR=2, MEMRD=3, LDWB=4, MEMWR=5, RTYPE=6, RWB=7, CBZ=8, HALT=9.
REQ-015 SHALL transition FETCH->DECODE unconditionally, asserting IRWrite=1 in FETCH.
REQ-016 SHALL transition DECODE->ADDR (LDUR/STUR), ->RTYPE (ADD/SUB/AND/ORR), ->CBZ (CBZ), ->HALT (illegal).
REQ-017 SHALL transition ADDR->MEMRD (LDUR) or ->MEMWR (STUR); ADDR drives ALUSrc=1, ALUOp=00.
REQ-018 SHALL hold MEMRD with MemRead=1 while mem_ready=0, advancing to LDWB on the cycle mem_ready=1.
REQ-019 SHALL drive LDWB: RegWrite=1, MemtoReg=1, PCWrite=1; then FETCH.
REQ-020 SHALL hold MEMWR with MemWrite=1 while mem_ready=0; on mem_ready=1 assert PCWrite=1 in that same cycle and go to FETCH.
REQ-021 SHALL drive RTYPE: ALUOp=10, ALUSrc=0; then RWB, which drives RegWrite=1, MemtoReg=0, ALUOp=10, PCWrite=1; then FETCH.
REQ-022 SHALL drive CBZ: ALUOp=01, PCWrite=1, PCSrc=Zero; then FETCH.
REQ-023 SHALL drive Reg2Loc=1 in DECODE and every later state of a STUR or CBZ instruction, else 0.
REQ-024 SHALL drive every control not listed for a state as 0 (no don't-cares).
REQ-025 SHALL yield latencies: CBZ 3 cycles; R-type 4; STUR 4+w; LDUR 5+w, w = mem_ready=0 wait cycles.
REQ-026 SHALL keep a wait counter, cleared on entry to MEMRD/MEMWR, incrementing each cycle mem_ready=0 there; when it reaches TIMEOUT with mem_ready still 0, go to HALT, dropping MemRead/MemWrite.
REQ-027 SHALL give mem_ready=1 precedence over timeout in the same cycle.
REQ-028 SHALL in HALT drive all controls 0 and fault=1, remaining there until reset.
REQ-029 SHALL pulse instr_done=1 and increment instret in exactly the cycles with PCWrite=1; instret wraps 0xFFFF->0x0000.
REQ-030 SHALL ignore mem_ready outside MEMRD/MEMWR.

Reset
REQ-031 SHALL on reset=1, asynchronously and regardless of clk, force state=FETCH, wait counter=0, instret=0, fault=0, instr_done=0.
REQ-032 SHALL abort any in-flight instruction (including a pending memory access) on reset with no PCWrite or RegWrite issued.
REQ-033 SHALL after reset deassertion enter DECODE on the first rising clk edge with IRWrite=1 in the preceding FETCH cycle.

Verification
REQ-034 SHALL verify ADD 10001011000: states 0,1,6,7,0; RegWrite=1 only in state 7; instret 0->1.
REQ-035 SHALL verify LDUR with mem_ready low 3 cycles: MemRead=1 four cycles in state 3, then LDWB with MemtoReg=1, RegWrite=1; 8 cycles total.
REQ-036 SHALL verify CBZ with Zero=1 -> PCSrc=1, PCWrite=1 in state 8; with Zero=0 -> PCSrc=0, PCWrite=1.
REQ-037 SHALL verify STUR with mem_ready never high, TIMEOUT=8 -> HALT after 8 wait cycles, fault=1, MemWrite=0, instret unchanged.
REQ-038 SHALL verify opcode 00000000000 -> HALT from DECODE, fault=1, all controls 0; reset mid-MEMRD -> state=0, instret=0 immediately.
REQ-039 SHALL verify 65536 retires wrap instret to 0x0000.
